// File: rtl/sha1_sched_pkg.sv
// Shared widths and defaults for the SHA-1 pipeline issue scheduler.
package sha1_sched_pkg;

    localparam int unsigned MSG_W    = 512;
    localparam int unsigned DIG_W    = 160;
    localparam int unsigned DEF_LAT  = 82;
    localparam int unsigned DEF_NREQ = 4;
    localparam int unsigned DEF_TAGW = 8;

endpackage

// File: rtl/rr_arbiter.sv
// N-wide round-robin arbiter: one-hot grant from valid, pointer advances past each accepted grant.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic                 clear,
    input  logic [N-1:0]         valid,
    output logic [N-1:0]         grant_c,
    output logic [$clog2(N)-1:0] grant_idx_c
);

    localparam int unsigned IDX_W = $clog2(N);

    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] idx;
    logic             found;

    // First valid requester at or after ptr, wrapping modulo N.
    always_comb begin
        grant_c     = '0;
        grant_idx_c = '0;
        found       = 1'b0;
        idx         = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = IDX_W'((32'(ptr) + k) % N);
            if (!found && valid[idx]) begin
                found       = 1'b1;
                grant_idx_c = idx;
            end
        end
        if (found && en) begin
            grant_c[grant_idx_c] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (clear) begin
            ptr <= '0;
        end else if (|grant_c) begin
            ptr <= (grant_idx_c == IDX_W'(N - 1)) ? '0 : grant_idx_c + IDX_W'(1);
        end
    end

endmodule

// File: rtl/sha1_pipe_sched.sv
// Issue scheduler for the unrolled SHA-1 pipeline: arbitrates requesters, tracks owner/tag
// alongside the datapath and returns digests. Optional counters under SHA1_SCHED_PERF_EN.
module sha1_pipe_sched
    import sha1_sched_pkg::*;
#(
    parameter int unsigned NREQ = DEF_NREQ,
    parameter int unsigned LAT  = DEF_LAT,
    parameter int unsigned TAGW = DEF_TAGW
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*MSG_W-1:0] req_msg,
    input  logic [NREQ*TAGW-1:0]  req_tag,
    output logic [NREQ-1:0]       req_ready,
    input  logic                  flush,
    output logic [MSG_W-1:0]      core_msg,
    input  logic [DIG_W-1:0]      core_digest,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [TAGW-1:0]       rsp_tag,
    output logic [DIG_W-1:0]      rsp_digest
`ifdef SHA1_SCHED_PERF_EN
    ,
    output logic [31:0]           perf_issued,
    output logic [31:0]           perf_idle
`endif
);

    localparam int unsigned ID_W = $clog2(NREQ);

    typedef struct packed {
        logic            valid;
        logic [ID_W-1:0] id;
        logic [TAGW-1:0] tag;
    } track_t;

    logic [NREQ-1:0]  grant_c;
    logic [ID_W-1:0]  gidx_c;
    logic             hs_c;
    logic [MSG_W-1:0] msg_sel_c;
    logic [TAGW-1:0]  tag_sel_c;

    // Index 0 sits beside core_msg, so LAT+1 stages line up with the digest sample edge.
    track_t trk [0:LAT];

    rr_arbiter #(
        .N (NREQ)
    ) u_arb (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (rst_n & ~flush),
        .clear       (flush),
        .valid       (req_valid),
        .grant_c     (grant_c),
        .grant_idx_c (gidx_c)
    );

    assign req_ready = grant_c;
    assign hs_c      = |grant_c;
    assign msg_sel_c = req_msg[MSG_W*32'(gidx_c) +: MSG_W];
    assign tag_sel_c = req_tag[TAGW*32'(gidx_c) +: TAGW];

    // core_msg only loads on a handshake to avoid toggling the datapath when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_msg <= '0;
        end else if (hs_c) begin
            core_msg <= msg_sel_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i <= LAT; i++) trk[i] <= '0;
        end else if (flush) begin
            for (int unsigned i = 0; i <= LAT; i++) trk[i] <= '0;
        end else begin
            trk[0] <= hs_c ? track_t'{valid: 1'b1, id: gidx_c, tag: tag_sel_c} : '0;
            for (int unsigned i = 1; i <= LAT; i++) trk[i] <= trk[i-1];
        end
    end

    // Response side: the oldest track entry pairs with the digest currently on the core output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid  <= '0;
            rsp_tag    <= '0;
            rsp_digest <= '0;
        end else if (flush || !trk[LAT].valid) begin
            rsp_valid  <= '0;
        end else begin
            rsp_valid  <= NREQ'(1) << trk[LAT].id;
            rsp_tag    <= trk[LAT].tag;
            rsp_digest <= core_digest;
        end
    end

`ifdef SHA1_SCHED_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued <= '0;
            perf_idle   <= '0;
        end else if (hs_c) begin
            perf_issued <= perf_issued + 32'd1;
        end else if (!flush) begin
            perf_idle   <= perf_idle + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_sha1_pipe_sched.sv
// Directed scoreboard bench for sha1_pipe_sched with a delay-line core model (LAT=4, NREQ=4).
module tb_sha1_pipe_sched;
    import sha1_sched_pkg::*;

    localparam int unsigned NREQ = 4;
    localparam int unsigned LAT  = 4;
    localparam int unsigned TAGW = 8;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*MSG_W-1:0] req_msg;
    logic [NREQ*TAGW-1:0]  req_tag;
    logic [NREQ-1:0]       req_ready;
    logic                  flush;
    logic [MSG_W-1:0]      core_msg;
    logic [DIG_W-1:0]      core_digest;
    logic [NREQ-1:0]       rsp_valid;
    logic [TAGW-1:0]       rsp_tag;
    logic [DIG_W-1:0]      rsp_digest;
`ifdef SHA1_SCHED_PERF_EN
    logic [31:0]           perf_issued;
    logic [31:0]           perf_idle;
`endif

    always #5 clk = ~clk;

    sha1_pipe_sched #(
        .NREQ (NREQ),
        .LAT  (LAT),
        .TAGW (TAGW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_msg     (req_msg),
        .req_tag     (req_tag),
        .req_ready   (req_ready),
        .flush       (flush),
        .core_msg    (core_msg),
        .core_digest (core_digest),
        .rsp_valid   (rsp_valid),
        .rsp_tag     (rsp_tag),
        .rsp_digest  (rsp_digest)
`ifdef SHA1_SCHED_PERF_EN
        ,
        .perf_issued (perf_issued),
        .perf_idle   (perf_idle)
`endif
    );

    function automatic logic [DIG_W-1:0] fold(input logic [MSG_W-1:0] m);
        return m[159:0] ^ m[319:160] ^ m[511:352];
    endfunction

    // Core model: free-running LAT-stage pipeline of a message fold.
    logic [DIG_W-1:0] dpipe [LAT];
    always @(posedge clk) begin
        dpipe[0] <= fold(core_msg);
        for (int i = 1; i < int'(LAT); i++) dpipe[i] <= dpipe[i-1];
    end
    assign core_digest = dpipe[LAT-1];

    typedef struct {
        int unsigned      id;
        logic [TAGW-1:0]  tag;
        logic [DIG_W-1:0] dig;
        int unsigned      cyc;
    } exp_t;

    exp_t            sbq[$];
    int              checks = 0;
    int              errors = 0;
    int unsigned     cyc = 0;
    int unsigned     ptr_m = 0;
    int unsigned     hs_cnt = 0;
    int unsigned     idle_cnt = 0;
    logic [NREQ-1:0] last_grant;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DIG_W-1:0] obs, input logic [DIG_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
        end
    endtask

    // Response monitor: every rsp_valid must match the oldest expected block, on its cycle.
    exp_t mon_e;
    always @(negedge clk) begin
        if (rst_n && rsp_valid !== '0) begin
            if (sbq.size() == 0) begin
                chk("rsp_unexpected", DIG_W'(rsp_valid), '0);
            end else begin
                mon_e = sbq.pop_front();
                chk("rsp_valid", DIG_W'(rsp_valid), DIG_W'(NREQ'(1) << mon_e.id));
                chk("rsp_tag", DIG_W'(rsp_tag), DIG_W'(mon_e.tag));
                chk("rsp_digest", rsp_digest, mon_e.dig);
                chk("rsp_cycle", DIG_W'(cyc), DIG_W'(mon_e.cyc));
            end
        end
    end

    // Entered at posedge+1: drive one cycle of inputs, check grant, record expectations.
    task automatic step(input logic [NREQ-1:0] v, input logic fl);
        logic [NREQ-1:0] exp_g;
        int unsigned     g;
        int unsigned     idx;
        req_valid = v;
        flush     = fl;
        for (int i = 0; i < int'(NREQ * MSG_W / 32); i++) req_msg[32*i +: 32] = $urandom;
        #1;
        exp_g = '0;
        g     = 0;
        if (!fl) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                idx = (ptr_m + k) % NREQ;
                if (exp_g == '0 && v[idx]) begin
                    exp_g = NREQ'(1) << idx;
                    g     = idx;
                end
            end
        end
        chk("req_ready", DIG_W'(req_ready), DIG_W'(exp_g));
        last_grant = req_ready;
        if (exp_g != '0) begin
            sbq.push_back('{g, req_tag[TAGW*g +: TAGW], fold(req_msg[MSG_W*g +: MSG_W]), cyc + LAT + 2});
            ptr_m = (g + 1) % NREQ;
            hs_cnt++;
        end else if (!fl) begin
            idle_cnt++;
        end
        if (fl) ptr_m = 0;
        @(posedge clk);
        #1;
        if (fl) sbq.delete();
    endtask

    task automatic drain();
        repeat (LAT + 3) step('0, 1'b0);
    endtask

`ifdef SHA1_SCHED_PERF_EN
    logic [31:0] p0;
`endif

    initial begin
        req_valid = '1;
        flush     = 1'b0;
        req_msg   = '0;
        req_tag   = {8'h77, 8'h5A, 8'h66, 8'h55};
        #1 rst_n = 1'b0;
        #1;
        chk("reset_req_ready", DIG_W'(req_ready), '0);
        chk("reset_rsp_valid", DIG_W'(rsp_valid), '0);
        chk("reset_core_msg", DIG_W'(core_msg), '0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        step('1, 1'b0);
        chk("first_grant", DIG_W'(last_grant), DIG_W'(4'b0001));

        step('0, 1'b0);
        step(4'b0100, 1'b0);
        chk("single_grant", DIG_W'(last_grant), DIG_W'(4'b0100));
        drain();

        step('0, 1'b1);
`ifdef SHA1_SCHED_PERF_EN
        p0 = perf_issued;
`endif
        for (int k = 0; k < 16; k++) begin
            req_tag = {TAGW'(k + 48), TAGW'(k + 32), TAGW'(k + 16), TAGW'(k)};
            step('1, 1'b0);
            chk("rr_grant", DIG_W'(last_grant), DIG_W'(NREQ'(1) << (k % 4)));
        end
`ifdef SHA1_SCHED_PERF_EN
        chk("perf_issued_16", DIG_W'(perf_issued - p0), DIG_W'(16));
`endif
        drain();

        step(4'b0010, 1'b0);
        step(4'b1010, 1'b0);
        chk("skip_grant_a", DIG_W'(last_grant), DIG_W'(4'b1000));
        step(4'b1010, 1'b0);
        chk("skip_grant_b", DIG_W'(last_grant), DIG_W'(4'b0010));
        step(4'b1010, 1'b0);
        chk("skip_grant_c", DIG_W'(last_grant), DIG_W'(4'b1000));
        drain();

        repeat (3) step(4'b0111, 1'b0);
        step('0, 1'b1);
        drain();
        step('1, 1'b0);
        chk("post_flush_grant", DIG_W'(last_grant), DIG_W'(4'b0001));
        drain();

        repeat (6) step('1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("async_rsp_valid", DIG_W'(rsp_valid), '0);
        chk("async_core_msg", DIG_W'(core_msg), '0);
        chk("async_req_ready", DIG_W'(req_ready), '0);
        sbq.delete();
        ptr_m    = 0;
        hs_cnt   = 0;
        idle_cnt = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        drain();
        step('1, 1'b0);
        chk("post_reset_grant", DIG_W'(last_grant), DIG_W'(4'b0001));
        drain();

`ifdef SHA1_SCHED_PERF_EN
        chk("perf_issued", DIG_W'(perf_issued), DIG_W'(hs_cnt));
        chk("perf_idle", DIG_W'(perf_idle), DIG_W'(idle_cnt));
`endif
        chk("sb_empty", DIG_W'(sbq.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
